// File: rtl/score_report_scheduler_pkg.sv
// Shared types for the score report scheduler: arbiter/classifier state encodings, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package score_report_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    CLS_COLLECT,
    CLS_SCAN,
    CLS_EMIT
  } cls_state_t;

  localparam int DROP_COUNT_WIDTH = 16;

endpackage

// File: rtl/score_report_scheduler_if.sv
// Word interface to the shared serial debug transmitter (SPI/UART front end).
// Latency: n/a (wires only).
// Backpressure: tx_axiready low means the transmitter is busy; the master must not strobe tx_axiiv.
interface score_report_scheduler_if #(
  parameter int SCORE_WIDTH = 32
);
  logic                   tx_axiiv;
  logic [SCORE_WIDTH-1:0] tx_axiid;
  logic                   tx_axiready;

  modport master (output tx_axiiv, output tx_axiid, input tx_axiready);
  modport slave  (input tx_axiiv, input tx_axiid, output tx_axiready);
endinterface

// File: rtl/score_report_scheduler_rr_priority_pick.sv
// Round-robin pick: first set request bit at or after ptr, wrapping at NUM_FILTERS.
// Latency: combinational.
// Backpressure: none; any=0 when no request is set.
module rr_priority_pick #(
  parameter  int NUM_FILTERS = 4,
  localparam int IDX_W       = $clog2(NUM_FILTERS)
) (
  input  logic [NUM_FILTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  // Walk offsets from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_FILTERS) j = j - NUM_FILTERS;
      if (req[j]) begin
        idx = IDX_W'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/score_report_scheduler.sv
// Latches matched-filter scores, shares one debug transmitter round-robin, and classifies each round by minimum score.
// Latency: word issued 2 cycles after its strobe when idle; class_valid NUM_FILTERS+1 cycles after a round completes.
// Backpressure: grants only while tx_axiready=1; re-strobing an unsent entry overwrites it (counted when SCORE_REPORT_DROP_COUNT_EN is defined).
module score_report_scheduler
  import score_report_pkg::*;
#(
  parameter  int NUM_FILTERS = 4,
  parameter  int SCORE_WIDTH = 32,
  localparam int IDX_W       = $clog2(NUM_FILTERS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_FILTERS-1:0]             score_valid,
  input  logic [NUM_FILTERS*SCORE_WIDTH-1:0] score_data,
  score_report_scheduler_if.master           tx,
  output logic                               class_valid,
  output logic [IDX_W-1:0]                   class_idx,
  output logic                               class_tie,
  output logic [DROP_COUNT_WIDTH-1:0]        drop_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

  // capture state
  logic [SCORE_WIDTH-1:0] hold [NUM_FILTERS];
  logic [SCORE_WIDTH-1:0] rnd  [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] pend;
  logic [NUM_FILTERS-1:0] seen;
  logic [NUM_FILTERS-1:0] clr_mask;

  // arbiter state
  arb_state_t             arb_state, arb_next;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   wait_first;
  logic                   issue;
  logic [SCORE_WIDTH-1:0] tx_dat_q;

  // classifier state
  cls_state_t             cls_state, cls_next;
  logic [SCORE_WIDTH-1:0] bank [NUM_FILTERS];
  logic [SCORE_WIDTH-1:0] best;
  logic [IDX_W-1:0]       best_idx;
  logic                   best_tie;
  logic [IDX_W-1:0]       scan_i;
  logic                   snap;

  assign snap = (cls_state == CLS_COLLECT) && (&seen);

  // Pending bit of the entry being sent is cleared; a same-cycle strobe re-sets it below.
  always_comb begin
    clr_mask = '0;
    if (issue) clr_mask[grant] = 1'b1;
  end

  // Score capture: hold feeds the transmitter, rnd feeds the next classification round.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      seen <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
        hold[i] <= '0;
        rnd[i]  <= '0;
      end
    end else begin
      pend <= (pend & ~clr_mask) | score_valid;
      seen <= (snap ? '0 : seen) | score_valid;
      for (int i = 0; i < NUM_FILTERS; i++) begin
        if (score_valid[i]) begin
          hold[i] <= score_data[i*SCORE_WIDTH +: SCORE_WIDTH];
          rnd[i]  <= score_data[i*SCORE_WIDTH +: SCORE_WIDTH];
        end
      end
    end
  end

  rr_priority_pick #(.NUM_FILTERS(NUM_FILTERS)) u_pick (
    .req (pend),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) arb_state <= ARB_IDLE;
    else     arb_state <= arb_next;
  end

  // Arbiter next state; ready in the first WAIT cycle is ignored since the transmitter has not yet reacted.
  always_comb begin
    arb_next = arb_state;
    case (arb_state)
      ARB_IDLE:  if (pick_any && tx.tx_axiready) arb_next = ARB_ISSUE;
      ARB_ISSUE: arb_next = ARB_WAIT;
      ARB_WAIT:  if (!wait_first && tx.tx_axiready) arb_next = ARB_IDLE;
      default:   arb_next = ARB_IDLE;
    endcase
  end

  // Arbiter outputs; the word is read live in ISSUE so a coinciding strobe still sends the old value.
  always_comb begin
    issue       = (arb_state == ARB_ISSUE);
    tx.tx_axiiv = issue;
    tx.tx_axiid = issue ? hold[grant] : tx_dat_q;
  end

  // Arbiter datapath: latch grant, advance pointer past it, keep the last sent word on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      ptr        <= '0;
      wait_first <= 1'b0;
      tx_dat_q   <= '0;
    end else begin
      wait_first <= issue;
      if (arb_state == ARB_IDLE && arb_next == ARB_ISSUE) grant <= pick_idx;
      if (issue) begin
        tx_dat_q <= hold[grant];
        ptr      <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
      end
    end
  end

  // Classifier state register.
  always_ff @(posedge clk) begin
    if (rst) cls_state <= CLS_COLLECT;
    else     cls_state <= cls_next;
  end

  // Classifier next state: collect a full round, scan entries 1..N-1, emit for one cycle.
  always_comb begin
    cls_next = cls_state;
    case (cls_state)
      CLS_COLLECT: if (&seen) cls_next = CLS_SCAN;
      CLS_SCAN:    if (scan_i == LAST_IDX) cls_next = CLS_EMIT;
      CLS_EMIT:    cls_next = CLS_COLLECT;
      default:     cls_next = CLS_COLLECT;
    endcase
  end

  // Classifier outputs are held at zero outside the emit cycle.
  always_comb begin
    class_valid = (cls_state == CLS_EMIT);
    class_idx   = (cls_state == CLS_EMIT) ? best_idx : '0;
    class_tie   = (cls_state == CLS_EMIT) && best_tie;
  end

  // Sequential argmin; only a strictly smaller score moves idx, so ties keep the lowest index.
  always_ff @(posedge clk) begin
    if (rst) begin
      best     <= '0;
      best_idx <= '0;
      best_tie <= 1'b0;
      scan_i   <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) bank[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_FILTERS; i++) bank[i] <= rnd[i];
      best     <= rnd[0];
      best_idx <= '0;
      best_tie <= 1'b0;
      scan_i   <= IDX_W'(1);
    end else if (cls_state == CLS_SCAN) begin
      if (bank[scan_i] < best) begin
        best     <= bank[scan_i];
        best_idx <= scan_i;
        best_tie <= 1'b0;
      end else if (bank[scan_i] == best) begin
        best_tie <= 1'b1;
      end
      scan_i <= scan_i + 1'b1;
    end
  end

`ifdef SCORE_REPORT_DROP_COUNT_EN
  localparam int DCW1 = DROP_COUNT_WIDTH + 1;

  logic [NUM_FILTERS-1:0]      drops;
  logic [DROP_COUNT_WIDTH-1:0] drop_cnt_q;
  logic [DROP_COUNT_WIDTH:0]   drop_sum;

  // A strobe onto an unsent entry is a drop; the entry being sent this cycle is not lost.
  assign drops      = score_valid & pend & ~clr_mask;
  assign drop_sum   = {1'b0, drop_cnt_q} + DCW1'($countones(drops));
  assign drop_count = drop_cnt_q;

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst)                           drop_cnt_q <= '0;
    else if (drop_sum[DROP_COUNT_WIDTH]) drop_cnt_q <= '1;
    else                               drop_cnt_q <= drop_sum[DROP_COUNT_WIDTH-1:0];
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_score_report_scheduler.sv
// Scoreboard bench for score_report_scheduler: directed plan cases plus randomized bursts.
// Expected transmit words and classifications come from a round-robin/argmin model.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_score_report_scheduler;

  localparam int N  = 4;
  localparam int SW = 32;
  localparam int IW = $clog2(N);

  typedef struct {
    logic [IW-1:0] idx;
    logic          tie;
    int            cyc;
  } cls_exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    score_valid;
  logic [N*SW-1:0] score_data;
  logic            class_valid;
  logic [IW-1:0]   class_idx;
  logic            class_tie;
  logic [15:0]     drop_count;

  score_report_scheduler_if #(.SCORE_WIDTH(SW)) txif ();

  score_report_scheduler #(.NUM_FILTERS(N), .SCORE_WIDTH(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .score_valid (score_valid),
    .score_data  (score_data),
    .tx          (txif),
    .class_valid (class_valid),
    .class_idx   (class_idx),
    .class_tie   (class_tie),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard and model state
  logic [SW-1:0] txq[$];
  cls_exp_t      clsq[$];
  logic [SW-1:0] sv [N];
  logic [SW-1:0] m_rnd [N];
  logic [N-1:0]  m_seen;
  int            m_ptr;
  int            m_drops;
  logic [SW-1:0] last_sent;

  int n_vec = 0;
  int n_fail = 0;
  int tx_cnt = 0;
  int class_cnt = 0;
  int last_tx_cyc = -100;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round model: once every filter has reported, the lowest score wins, the lowest index breaks ties.
  task automatic model_round_check(input int strobe_cyc);
    cls_exp_t e;
    logic [SW-1:0] mn;
    int cnt;
    if (&m_seen) begin
      mn = m_rnd[0];
      for (int i = 1; i < N; i++) if (m_rnd[i] < mn) mn = m_rnd[i];
      cnt = 0;
      e.idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (m_rnd[i] == mn) begin
          cnt++;
          e.idx = IW'(i);
        end
      end
      e.tie = (cnt > 1);
      e.cyc = strobe_cyc + N + 1;
      clsq.push_back(e);
      m_seen = '0;
    end
  endtask

  // One-cycle strobe of every filter in mask with values sv[]; nothing else may be pending.
  task automatic burst(input logic [N-1:0] mask);
    int t;
    int lastj;
    t = cyc;
    lastj = -1;
    for (int i = 0; i < N; i++) score_data[i*SW +: SW] = sv[i];
    score_valid = mask;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (mask[j]) begin
        txq.push_back(sv[j]);
        last_sent = sv[j];
        lastj = j;
      end
    end
    if (lastj >= 0) m_ptr = (lastj + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        m_rnd[i]  = sv[i];
        m_seen[i] = 1'b1;
      end
    end
    model_round_check(t);
    step();
    score_valid = '0;
  endtask

  task automatic drain(input bit rnd_rdy);
    for (int c = 0; c < 600; c++) begin
      if (txq.size() == 0 && clsq.size() == 0) break;
      txif.tx_axiready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
    end
    txif.tx_axiready = 1'b1;
    if (txq.size() != 0 || clsq.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words and %0d classifications outstanding, expected 0", txq.size(), clsq.size());
      txq.delete();
      clsq.delete();
    end else begin
      check("tx_hold", txif.tx_axiid, last_sent);
    end
    repeat (2) step();
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    if (txif.tx_axiiv) begin
      tx_cnt++;
      if (last_tx_cyc >= 0) check("tx_gap_ge3", (cyc - last_tx_cyc) >= 3, 1);
      last_tx_cyc = cyc;
      if (txq.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL tx_unexpected: got word 0x%0h, expected no transmit", txif.tx_axiid);
      end else begin
        check("tx_data", txif.tx_axiid, txq.pop_front());
      end
    end
    if (class_valid) begin
      class_cnt++;
      if (clsq.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL class_unexpected: got idx %0d tie %0d, expected no class_valid", class_idx, class_tie);
      end else begin
        cls_exp_t e;
        e = clsq.pop_front();
        check("class_idx", class_idx, e.idx);
        check("class_tie", class_tie, e.tie);
        check("class_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int exp_drop;
    rst = 1'b1;
    score_valid = '0;
    score_data = '0;
    txif.tx_axiready = 1'b1;
    m_seen = '0;
    m_ptr = 0;
    m_drops = 0;
    last_sent = '0;
    for (int i = 0; i < N; i++) m_rnd[i] = '0;
    repeat (3) step();

    // reset state
    check("rst_tx_axiiv", txif.tx_axiiv, 0);
    check("rst_tx_axiid", txif.tx_axiid, 0);
    check("rst_class_valid", class_valid, 0);
    check("rst_class_idx", class_idx, 0);
    check("rst_class_tie", class_tie, 0);
    check("rst_drop_count", drop_count, 0);
    rst = 1'b0;
    step();

    // round-robin order 10,20,30,40; round argmin is filter 0
    sv[0] = 10; sv[1] = 20; sv[2] = 30; sv[3] = 40;
    burst(4'b1111);
    drain(0);

    // backpressure: nothing leaves while ready is low
    txif.tx_axiready = 1'b0;
    sv[2] = 7;
    burst(4'b0100);
    c0 = tx_cnt;
    repeat (100) step();
    check("bp_no_tx", tx_cnt, c0);
    drain(0);
    check("bp_single_tx", tx_cnt, c0 + 1);

    // argmin 500,120,300,999 -> idx 1, no tie
    sv[0] = 500; sv[1] = 120; sv[2] = 300; sv[3] = 999;
    burst(4'b1111);
    drain(0);

    // tie 50,80,50,90 -> idx 0, tie
    sv[0] = 50; sv[1] = 80; sv[2] = 50; sv[3] = 90;
    burst(4'b1111);
    drain(0);

    // overflow: filter 3 strobed 5,6,7 while blocked; only 7 is sent
    txif.tx_axiready = 1'b0;
    c0 = tx_cnt;
    for (int v = 5; v <= 7; v++) begin
      score_data[3*SW +: SW] = SW'(v);
      score_valid = 4'b1000;
      step();
    end
    score_valid = '0;
    txq.push_back(7);
    last_sent = 7;
    m_ptr = 0;
    m_rnd[3] = 7;
    m_seen[3] = 1'b1;
    m_drops += 2;
    model_round_check(cyc - 1);
    repeat (10) step();
    check("ovf_no_tx", tx_cnt, c0);
    drain(0);
    check("ovf_single_tx", tx_cnt, c0 + 1);
`ifdef SCORE_REPORT_DROP_COUNT_EN
    exp_drop = (m_drops > 65535) ? 65535 : m_drops;
`else
    exp_drop = 0;
`endif
    check("drop_count", drop_count, exp_drop);

    // randomized bursts under random backpressure
    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] mask;
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) sv[i] = ($urandom_range(0, 1) != 0) ? SW'($urandom_range(0, 7)) : SW'($urandom());
      txif.tx_axiready = ($urandom_range(0, 1) != 0);
      burst(mask);
      drain(1);
    end

    // move pointer off 0, then reset mid-WAIT and mid-SCAN
    sv[0] = 3;
    burst(4'b0001);
    drain(0);
    for (int i = 0; i < N; i++) sv[i] = SW'(100 + i);
    c0 = tx_cnt;
    c0 = c0 + 0;
    burst(4'b1111);
    for (int c = 0; c < 20; c++) begin
      if (tx_cnt > c0) break;
      step();
    end
    check("pre_reset_tx_seen", tx_cnt > c0, 1);
    rst = 1'b1;
    txq.delete();
    clsq.delete();
    m_seen = '0;
    m_ptr = 0;
    m_drops = 0;
    for (int i = 0; i < N; i++) m_rnd[i] = '0;
    step();
    rst = 1'b0;
    last_sent = '0;
    last_tx_cyc = -100;
    check("mid_rst_tx_axiiv", txif.tx_axiiv, 0);
    check("mid_rst_tx_axiid", txif.tx_axiid, 0);
    check("mid_rst_class_valid", class_valid, 0);
    check("mid_rst_class_idx", class_idx, 0);
    check("mid_rst_class_tie", class_tie, 0);
    check("mid_rst_drop_count", drop_count, 0);
    c0 = class_cnt;
    repeat (N + 4) step();
    check("mid_rst_no_class", class_cnt, c0);
    check("mid_rst_no_tx", txif.tx_axiiv, 0);

    // pointer restarts at filter 0
    for (int i = 0; i < N; i++) sv[i] = SW'(200 + i);
    burst(4'b1111);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/score_report_scheduler.md
Name: score_report_scheduler

Overview:
- Sits downstream of the bank of matched filters.
- Latches each filter's match score as it is produced and shares one serial debug transmitter (SPI or UART word interface) between all filters using round-robin.
- After every filter has reported once in a round, scans the round's scores sequentially and issues a minimum-score classification that drives the LEDs.

Parameters:
- NUM_FILTERS, 4, number of score sources (2..16).
- SCORE_WIDTH, 32, bits per match score, unsigned.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- score_valid  input  NUM_FILTERS  per-filter one-cycle score strobe
- score_data  input  NUM_FILTERS*SCORE_WIDTH  packed scores; filter i occupies bits [i*SCORE_WIDTH +: SCORE_WIDTH]
- tx_axiiv  output  1  one-cycle transmit request
- tx_axiid  output  SCORE_WIDTH  word to transmit
- tx_axiready  input  1  transmitter idle
- class_valid  output  1  one-cycle classification strobe
- class_idx  output  $clog2(NUM_FILTERS)  index of minimum score
- class_tie  output  1  minimum shared by two or more filters
- drop_count  output  16  dropped-score counter (see Optional Feature)

Behaviour:
- Reset clears every output to 0, all pending, seen and score registers, and the round-robin pointer (to 0). The arbiter FSM returns to IDLE. Reset mid-transfer abandons the word.
- Capture, per filter i:
  - On score_valid[i], load hold[i] and set pend[i].
  - If pend[i] is already set, overwrite hold[i] and record a drop.
  - If score_valid[i] coincides with that entry being granted, the granted word is the old hold[i]; the new value is stored and pend[i] stays set.
  - Also on score_valid[i], load rnd[i] and set seen[i].
- Arbiter FSM, states IDLE, ISSUE, WAIT:
  - IDLE: when any pend bit is set and tx_axiready=1, grant the first pending index at or after the pointer (with wrap), then go to ISSUE.
  - ISSUE: tx_axiiv=1 for exactly one cycle with tx_axiid=hold[grant]. Clear pend[grant], set pointer=grant+1 (wrapping at NUM_FILTERS), go to WAIT.
  - WAIT: tx_axiiv=0. Return to IDLE on the first cycle with tx_axiready=1 that is not the cycle immediately after ISSUE. This guarantees at least one WAIT cycle.
  - tx_axiid holds its value until the next ISSUE.
- Classifier FSM, states COLLECT, SCAN, EMIT:
  - COLLECT: when all seen bits are set, snapshot rnd into the scan bank, clear seen, and go to SCAN.
  - SCAN: one comparison per cycle, i = 1..NUM_FILTERS-1, unsigned. Strictly smaller updates best/idx and clears tie. Equal to best sets tie. best and idx start from entry 0 with tie=0.
  - EMIT: class_valid=1 for one cycle with class_idx and class_tie. On a tie, class_idx is the lowest tied index. Then return to COLLECT.
  - Latency: class_valid rises NUM_FILTERS+1 cycles after the cycle in which the last seen bit is set.
  - Scores arriving during SCAN/EMIT update rnd/seen for the next round; the scan bank is unaffected.
- The arbiter and classifier run independently. A source may be granted in the same cycle it completes a round.

Optional Feature:
- Macro SCORE_REPORT_DROP_COUNT_EN.
- Defined: drop_count increments by 1 on each overwrite of a pending hold entry, saturating at 16'hFFFF. Multiple drops in one cycle add their popcount, still saturating. Reset clears it.
- Undefined: drop_count is tied to 0 and no counter logic is built.

Decomposition:
- Package score_report_pkg holds:
  - arbiter state enum (IDLE/ISSUE/WAIT);
  - classifier state enum (COLLECT/SCAN/EMIT);
  - DROP_COUNT_WIDTH=16.
- Sub-module rr_priority_pick: combinational first-set-bit-at-or-after-pointer over NUM_FILTERS, producing grant index and any-valid.

Test Plan:
1. Round-robin ordering: NUM_FILTERS=4, tx_axiready=1 held, scores 10,20,30,40 strobed in the same cycle -> four ISSUE pulses carrying 10,20,30,40 in order, each separated by at least 2 cycles.
2. Backpressure: tx_axiready=0 for 100 cycles with score 7 pending on filter 2 -> no tx_axiiv; a single pulse with data 7 follows tx_axiready rising.
3. Argmin: round scores 500,120,300,999 -> class_valid one cycle, class_idx=1, class_tie=0, exactly 5 cycles after the last strobe.
4. Tie: round scores 50,80,50,90 -> class_idx=0, class_tie=1.
5. Overflow: filter 3 strobed 5,6,7 with tx_axiready=0 -> one transmit of 7 when ready rises. With the macro defined drop_count=2; without it drop_count=0.
6. Reset mid-WAIT and mid-SCAN -> all outputs 0 on the next cycle, no class_valid, and pointer restarts at filter 0.
